// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_pkg
// Description : Shared types and defaults for the ID operand stage:
//               write-condition encoding, default field widths and the
//               hard-wired zero register address.
// Revision    : 1.0 - initial release
// ============================================================================
package id_pkg;

  // Conditional destination write (MOVN/MOVZ style), evaluated on op1
  typedef enum logic [1:0] {
    ALWAYS    = 2'd0,
    IF_OP1_NZ = 2'd1,
    IF_OP1_Z  = 2'd2
  } write_cond_e;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_REG_AW    = 5;
  localparam int DEF_N_FWD     = 2;
  localparam int DEF_ALU_OP_W  = 8;
  localparam int DEF_ALU_SEL_W = 3;

  // Register 0 is hard-wired; it is never a forwarding target
  localparam int unsigned REG_ZERO = 0;

endpackage
`default_nettype wire

// File: rtl/id_operand_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Resolves one source operand. Scans forwarding sources from
//               index 0 (youngest) upward; the first source writing the same
//               non-zero register wins. A winning source whose data is not yet
//               ready raises hazard. With ren=0 the immediate is selected.
// Ports       : addr, ren        - source register address / read enable
//               rf_data, imm     - regfile read data / immediate
//               fwd_wen/waddr/wdata/rdy - packed forwarding buses
//               operand, hazard  - resolved value / value-pending flag
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
  import id_pkg::*;
#(
  parameter int N_FWD  = DEF_N_FWD,
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0]        addr,
  input  logic                     ren,
  input  logic [DATA_W-1:0]        rf_data,
  input  logic [DATA_W-1:0]        imm,
  input  logic [N_FWD-1:0]         fwd_wen,
  input  logic [N_FWD*REG_AW-1:0]  fwd_waddr,
  input  logic [N_FWD*DATA_W-1:0]  fwd_wdata,
  input  logic [N_FWD-1:0]         fwd_rdy,
  output logic [DATA_W-1:0]        operand,
  output logic                     hazard
);

  logic              found;
  logic              pending;
  logic [DATA_W-1:0] sel_data;

  // Priority scan: once a source matched, older sources are ignored, so a
  // pending younger write blocks even when an older one holds ready data.
  always_comb begin
    found    = 1'b0;
    pending  = 1'b0;
    sel_data = rf_data;
    for (int k = 0; k < N_FWD; k++) begin
      if (!found && fwd_wen[k] &&
          (fwd_waddr[k*REG_AW +: REG_AW] == addr) &&
          (addr != REG_AW'(REG_ZERO))) begin
        found    = 1'b1;
        pending  = !fwd_rdy[k];
        sel_data = fwd_wdata[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    operand = imm;
    hazard  = 1'b0;
    if (ren) begin
      operand = sel_data;
      hazard  = pending;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_operand_stage
// Description : Operand resolution with multi-source forwarding, load-use
//               hazard stall, conditional-write resolution and ID/EX pipeline
//               register with valid/ready handshake and flush.
// Config      : ID_STALL_CNT_EN - when defined, o_stall_cnt counts hazard
//               stall cycles (saturating); otherwise it is tied to 0.
// Ports       : clk, i_rst_n (sync, active-low)
//               i_valid/o_ready        - upstream handshake
//               i_rs_*/i_rt_*, i_imm   - source fields and regfile data
//               i_alu_op/i_alu_sel, i_wen/i_wen_cond/i_waddr - decoded fields
//               i_fwd_*                - packed forwarding sources (0=youngest)
//               i_flush                - kill in-stage and incoming instr
//               i_ready/o_valid        - downstream handshake
//               o_op0/o_op1, o_alu_*, o_wen, o_waddr - ID/EX register
//               o_stall_cnt            - hazard stall cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module id_operand_stage
  import id_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int REG_AW    = DEF_REG_AW,
  parameter int N_FWD     = DEF_N_FWD,
  parameter int ALU_OP_W  = DEF_ALU_OP_W,
  parameter int ALU_SEL_W = DEF_ALU_SEL_W
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [REG_AW-1:0]        i_rs_addr,
  input  logic [REG_AW-1:0]        i_rt_addr,
  input  logic                     i_rs_ren,
  input  logic                     i_rt_ren,
  input  logic [DATA_W-1:0]        i_rs_data,
  input  logic [DATA_W-1:0]        i_rt_data,
  input  logic [DATA_W-1:0]        i_imm,
  input  logic [ALU_OP_W-1:0]      i_alu_op,
  input  logic [ALU_SEL_W-1:0]     i_alu_sel,
  input  logic                     i_wen,
  input  logic [1:0]               i_wen_cond,
  input  logic [REG_AW-1:0]        i_waddr,
  input  logic [N_FWD-1:0]         i_fwd_wen,
  input  logic [N_FWD*REG_AW-1:0]  i_fwd_waddr,
  input  logic [N_FWD*DATA_W-1:0]  i_fwd_wdata,
  input  logic [N_FWD-1:0]         i_fwd_rdy,
  input  logic                     i_flush,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_op0,
  output logic [DATA_W-1:0]        o_op1,
  output logic [ALU_OP_W-1:0]      o_alu_op,
  output logic [ALU_SEL_W-1:0]     o_alu_sel,
  output logic                     o_wen,
  output logic [REG_AW-1:0]        o_waddr,
  output logic [31:0]              o_stall_cnt
);

  logic [DATA_W-1:0] rs_op;
  logic [DATA_W-1:0] rt_op;
  logic              rs_hazard;
  logic              rt_hazard;
  logic              hazard;
  logic              wen_resolved;

  fwd_mux #(
    .N_FWD  (N_FWD),
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rs (
    .addr      (i_rs_addr),
    .ren       (i_rs_ren),
    .rf_data   (i_rs_data),
    .imm       (i_imm),
    .fwd_wen   (i_fwd_wen),
    .fwd_waddr (i_fwd_waddr),
    .fwd_wdata (i_fwd_wdata),
    .fwd_rdy   (i_fwd_rdy),
    .operand   (rs_op),
    .hazard    (rs_hazard)
  );

  fwd_mux #(
    .N_FWD  (N_FWD),
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_fwd_rt (
    .addr      (i_rt_addr),
    .ren       (i_rt_ren),
    .rf_data   (i_rt_data),
    .imm       (i_imm),
    .fwd_wen   (i_fwd_wen),
    .fwd_waddr (i_fwd_waddr),
    .fwd_wdata (i_fwd_wdata),
    .fwd_rdy   (i_fwd_rdy),
    .operand   (rt_op),
    .hazard    (rt_hazard)
  );

  assign hazard = i_valid && (rs_hazard || rt_hazard);

  // Flush always drains the incoming instruction, even under a hazard.
  // This path is purely combinational from the forwarding inputs.
  assign o_ready = i_flush || (!hazard && (!o_valid || i_ready));

  // Condition is evaluated on the forwarded op1 value; the unused encoding
  // suppresses the write.
  always_comb begin
    wen_resolved = 1'b0;
    case (write_cond_e'(i_wen_cond))
      ALWAYS:    wen_resolved = i_wen;
      IF_OP1_NZ: wen_resolved = i_wen && (rt_op != '0);
      IF_OP1_Z:  wen_resolved = i_wen && (rt_op == '0);
      default:   wen_resolved = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_op0     <= '0;
      o_op1     <= '0;
      o_alu_op  <= '0;
      o_alu_sel <= '0;
      o_wen     <= 1'b0;
      o_waddr   <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (i_valid && o_ready) begin
      o_valid   <= 1'b1;
      o_op0     <= rs_op;
      o_op1     <= rt_op;
      o_alu_op  <= i_alu_op;
      o_alu_sel <= i_alu_sel;
      o_wen     <= wen_resolved;
      o_waddr   <= i_waddr;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
    end else if (hazard && !i_flush && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_operand_stage
// Description : Self-checking bench for id_operand_stage (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready_out;
  logic [4:0]  rs_addr, rt_addr;
  logic        rs_ren, rt_ren;
  logic [31:0] rs_data, rt_data, imm;
  logic [7:0]  alu_op;
  logic [2:0]  alu_sel;
  logic        wen;
  logic [1:0]  wen_cond;
  logic [4:0]  waddr;
  logic        flush;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] op0, op1;
  logic [7:0]  alu_op_out;
  logic [2:0]  alu_sel_out;
  logic        wen_out;
  logic [4:0]  waddr_out;
  logic [31:0] stall_cnt;

  logic        fw_we [2];
  logic [4:0]  fw_a  [2];
  logic [31:0] fw_d  [2];
  logic        fw_r  [2];

  logic [1:0]  fwd_wen;
  logic [9:0]  fwd_waddr;
  logic [63:0] fwd_wdata;
  logic [1:0]  fwd_rdy;

  assign fwd_wen   = {fw_we[1], fw_we[0]};
  assign fwd_waddr = {fw_a[1], fw_a[0]};
  assign fwd_wdata = {fw_d[1], fw_d[0]};
  assign fwd_rdy   = {fw_r[1], fw_r[0]};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_operand_stage dut (
    .clk         (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .o_ready     (ready_out),
    .i_rs_addr   (rs_addr),
    .i_rt_addr   (rt_addr),
    .i_rs_ren    (rs_ren),
    .i_rt_ren    (rt_ren),
    .i_rs_data   (rs_data),
    .i_rt_data   (rt_data),
    .i_imm       (imm),
    .i_alu_op    (alu_op),
    .i_alu_sel   (alu_sel),
    .i_wen       (wen),
    .i_wen_cond  (wen_cond),
    .i_waddr     (waddr),
    .i_fwd_wen   (fwd_wen),
    .i_fwd_waddr (fwd_waddr),
    .i_fwd_wdata (fwd_wdata),
    .i_fwd_rdy   (fwd_rdy),
    .i_flush     (flush),
    .i_ready     (ready_in),
    .o_valid     (valid_out),
    .o_op0       (op0),
    .o_op1       (op1),
    .o_alu_op    (alu_op_out),
    .o_alu_sel   (alu_sel_out),
    .o_wen       (wen_out),
    .o_waddr     (waddr_out),
    .o_stall_cnt (stall_cnt)
  );

  // ---------------- reference model ----------------
  // Operand value: immediate when not read; reg 0 is always the regfile;
  // otherwise the lowest-index forwarding source writing this register, and
  // if that source's data is not ready the operand is pending.
  function automatic logic [31:0] ref_op(input logic [4:0] a, input logic ren,
                                         input logic [31:0] rf, input logic [31:0] im,
                                         output logic haz);
    haz = 1'b0;
    if (!ren) return im;
    if (a == 5'd0) return rf;
    for (int k = 0; k < 2; k++) begin
      if (fw_we[k] && fw_a[k] == a) begin
        haz = !fw_r[k];
        return fw_d[k];
      end
    end
    return rf;
  endfunction

  function automatic logic ref_wen(input logic w, input logic [1:0] c, input logic [31:0] o1);
    if (c == 2'd0) return w;
    if (c == 2'd1) return w && (o1 != 0);
    if (c == 2'd2) return w && (o1 == 0);
    return 1'b0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid = 0; rs_addr = 0; rt_addr = 0; rs_ren = 0; rt_ren = 0;
    rs_data = 0; rt_data = 0; imm = 0; alu_op = 0; alu_sel = 0;
    wen = 0; wen_cond = 0; waddr = 0; flush = 0; ready_in = 1;
    for (int k = 0; k < 2; k++) begin
      fw_we[k] = 0; fw_a[k] = 0; fw_d[k] = 0; fw_r[k] = 1;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    valid = 1; rs_ren = 0; rt_ren = 0; imm = 32'h1234; alu_op = 8'h5A;
    alu_sel = 3'd5; wen = 1; waddr = 5'd9;
    tick(); tick();
    total++;
    if ({valid_out, op0, op1, alu_op_out, alu_sel_out, wen_out, waddr_out, stall_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b op0=%h op1=%h aop=%h asel=%h w=%b wa=%h sc=%0d need all 0",
               valid_out, op0, op1, alu_op_out, alu_sel_out, wen_out, waddr_out, stall_cnt);
    end
    rst_n = 1;
    #1;
    total++;
    if (ready_out !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready got=%b need=1", ready_out);
    end
    tick();
    total++;
    if (valid_out !== 1'b1 || op0 !== 32'h1234 || op1 !== 32'h1234 ||
        alu_op_out !== 8'h5A || alu_sel_out !== 3'd5 || wen_out !== 1'b1 || waddr_out !== 5'd9) begin
      bad++;
      $display("FAIL first_accept got v=%b op0=%h op1=%h aop=%h asel=%h w=%b wa=%h need 1/1234/1234/5a/5/1/09",
               valid_out, op0, op1, alu_op_out, alu_sel_out, wen_out, waddr_out);
    end
    valid = 0;
    tick();
  endtask

  task automatic test_fwd_priority();
    logic [31:0] exp [3];
    do_reset();
    exp[0] = 32'hAAAA; exp[1] = 32'hBBBB; exp[2] = 32'h1111;
    valid = 1; rs_addr = 5'd3; rs_ren = 1; rs_data = 32'h1111;
    fw_we[0] = 1; fw_a[0] = 5'd3; fw_d[0] = 32'hAAAA; fw_r[0] = 1;
    fw_we[1] = 1; fw_a[1] = 5'd3; fw_d[1] = 32'hBBBB; fw_r[1] = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) fw_we[0] = 0;
      if (i == 2) fw_we[1] = 0;
      tick();
      total++;
      if (op0 !== exp[i] || valid_out !== 1'b1) begin
        bad++; $display("FAIL fwd_priority step=%0d got op0=%h v=%b need op0=%h v=1", i, op0, valid_out, exp[i]);
      end
    end
    valid = 0;
    tick();
  endtask

  task automatic test_load_use();
    logic [31:0] exp_sc;
    do_reset();
    valid = 1; rt_addr = 5'd5; rt_ren = 1; rt_data = 32'h9999; rs_ren = 0;
    fw_we[0] = 1; fw_a[0] = 5'd5; fw_d[0] = 32'hDEAD; fw_r[0] = 0;
    // older source holds ready data for the same register: must still block
    fw_we[1] = 1; fw_a[1] = 5'd5; fw_d[1] = 32'h0077; fw_r[1] = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++;
      if (ready_out !== 1'b0) begin
        bad++; $display("FAIL load_use_stall cyc=%0d got ready=%b need 0", c, ready_out);
      end
      tick();
      total++;
      if (valid_out !== 1'b0) begin
        bad++; $display("FAIL load_use_bubble cyc=%0d got valid=%b need 0", c, valid_out);
      end
    end
    fw_r[0] = 1; fw_d[0] = 32'h42;
    #1;
    total++;
    if (ready_out !== 1'b1) begin
      bad++; $display("FAIL load_use_release got ready=%b need 1", ready_out);
    end
    tick();
    total++;
    if (valid_out !== 1'b1 || op1 !== 32'h42) begin
      bad++; $display("FAIL load_use_data got v=%b op1=%h need v=1 op1=42", valid_out, op1);
    end
`ifdef ID_STALL_CNT_EN
    exp_sc = 32'd2;
`else
    exp_sc = 32'd0;
`endif
    total++;
    if (stall_cnt !== exp_sc) begin
      bad++; $display("FAIL load_use_stall_cnt got=%0d need=%0d", stall_cnt, exp_sc);
    end
    valid = 0;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    valid = 1; rs_addr = 5'd7; rs_ren = 1;
    fw_we[0] = 1; fw_a[0] = 5'd7; fw_r[0] = 0;
    tick(); tick();
    rst_n = 0;
    tick();
    total++;
    if (valid_out !== 1'b0 || stall_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_mid_stall got v=%b sc=%0d need 0/0", valid_out, stall_cnt);
    end
    rst_n = 1; valid = 0;
    tick(); tick();
    total++;
    if (valid_out !== 1'b0 || stall_cnt !== 32'd0 || ready_out !== 1'b1) begin
      bad++; $display("FAIL reset_no_resume got v=%b sc=%0d rdy=%b need 0/0/1", valid_out, stall_cnt, ready_out);
    end
  endtask

  task automatic test_zero_reg();
    do_reset();
    valid = 1; rs_addr = 5'd0; rs_ren = 1; rs_data = 32'h0;
    fw_we[0] = 1; fw_a[0] = 5'd0; fw_d[0] = 32'hFFFF; fw_r[0] = 1;
    for (int i = 0; i < 2; i++) begin
      fw_r[0] = (i == 0);   // pending write to reg 0 must not stall either
      #1;
      total++;
      if (ready_out !== 1'b1) begin
        bad++; $display("FAIL zero_reg_ready step=%0d got=%b need 1", i, ready_out);
      end
      tick();
      total++;
      if (op0 !== 32'h0 || valid_out !== 1'b1) begin
        bad++; $display("FAIL zero_reg_op step=%0d got op0=%h v=%b need 0/1", i, op0, valid_out);
      end
    end
    valid = 0;
    tick();
  endtask

  task automatic test_cond_write();
    logic [1:0]  c_cond [6];
    logic [31:0] c_data [6];
    logic        c_wen  [6];
    logic        c_exp  [6];
    c_cond = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd1};
    c_data = '{32'd0, 32'd7, 32'd0, 32'd7, 32'd0, 32'd7};
    c_wen  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    c_exp  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    valid = 1; rt_addr = 5'd6; rt_ren = 1; rt_data = 32'h55;
    fw_we[0] = 1; fw_a[0] = 5'd6; fw_r[0] = 1;
    for (int i = 0; i < 6; i++) begin
      wen_cond = c_cond[i]; fw_d[0] = c_data[i]; wen = c_wen[i];
      tick();
      total++;
      if (wen_out !== c_exp[i] || op1 !== c_data[i]) begin
        bad++; $display("FAIL cond_write step=%0d got wen=%b op1=%h need wen=%b op1=%h",
                        i, wen_out, op1, c_exp[i], c_data[i]);
      end
    end
    valid = 0; wen_cond = 0;
    tick();
  endtask

  task automatic test_hold_flush();
    logic [31:0] a_imm;
    a_imm = $urandom;
    do_reset();
    valid = 1; rs_ren = 0; rt_ren = 0; imm = a_imm; alu_op = 8'hC3; waddr = 5'd12; wen = 1;
    tick();
    ready_in = 0;
    imm = ~a_imm; alu_op = 8'h3C; waddr = 5'd4; rs_ren = 1; rs_addr = 5'd2;
    for (int c = 0; c < 3; c++) begin
      fw_we[c % 2] = 1; fw_a[c % 2] = 5'd2; fw_d[c % 2] = $urandom; fw_r[c % 2] = c[0];
      #1;
      total++;
      if (ready_out !== 1'b0) begin
        bad++; $display("FAIL hold_ready cyc=%0d got=%b need 0", c, ready_out);
      end
      tick();
      total++;
      if (valid_out !== 1'b1 || op0 !== a_imm || op1 !== a_imm || alu_op_out !== 8'hC3 || waddr_out !== 5'd12) begin
        bad++; $display("FAIL hold_stable cyc=%0d got v=%b op0=%h aop=%h wa=%0d need 1/%h/c3/12",
                        c, valid_out, op0, alu_op_out, waddr_out, a_imm);
      end
    end
    flush = 1;
    #1;
    total++;
    if (ready_out !== 1'b1) begin
      bad++; $display("FAIL flush_ready got=%b need 1", ready_out);
    end
    tick();
    total++;
    if (valid_out !== 1'b0) begin
      bad++; $display("FAIL flush_valid got=%b need 0", valid_out);
    end
    flush = 0; valid = 0; ready_in = 1;
    tick();
    total++;
    if (valid_out !== 1'b0) begin
      bad++; $display("FAIL flush_dropped got=%b need 0", valid_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    do_reset();
    valid = 1; ready_in = 1; rs_ren = 0; rt_ren = 0;
    for (int i = 0; i < 5; i++) begin
      v = $urandom;
      imm = v;
      #1;
      total++;
      if (ready_out !== 1'b1) begin
        bad++; $display("FAIL b2b_ready i=%0d got=%b need 1", i, ready_out);
      end
      tick();
      total++;
      if (valid_out !== 1'b1 || op0 !== v) begin
        bad++; $display("FAIL b2b_data i=%0d got v=%b op0=%h need 1/%h", i, valid_out, op0, v);
      end
    end
    valid = 0;
    tick();
  endtask

  task automatic test_random();
    logic        e_valid;
    logic [31:0] e_op0, e_op1;
    logic [7:0]  e_aop;
    logic [2:0]  e_asel;
    logic        e_wen;
    logic [4:0]  e_wa;
    logic [31:0] e_sc;
    logic [31:0] r0, r1, e_sc_cfg;
    logic        h0, h1, haz, rdy;
    do_reset();
    e_valid = 0; e_op0 = 0; e_op1 = 0; e_aop = 0; e_asel = 0; e_wen = 0; e_wa = 0; e_sc = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      valid    = ($urandom_range(0, 3) != 0);
      rs_addr  = 5'($urandom_range(0, 3));
      rt_addr  = 5'($urandom_range(0, 3));
      rs_ren   = ($urandom_range(0, 4) != 0);
      rt_ren   = ($urandom_range(0, 4) != 0);
      rs_data  = $urandom; rt_data = $urandom;
      imm      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      alu_op   = 8'($urandom); alu_sel = 3'($urandom);
      wen      = 1'($urandom); wen_cond = 2'($urandom_range(0, 2));
      waddr    = 5'($urandom);
      flush    = ($urandom_range(0, 15) == 0);
      ready_in = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < 2; k++) begin
        fw_we[k] = 1'($urandom);
        fw_a[k]  = 5'($urandom_range(0, 3));
        fw_d[k]  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        fw_r[k]  = ($urandom_range(0, 3) != 0);
      end
      r0  = ref_op(rs_addr, rs_ren, rs_data, imm, h0);
      r1  = ref_op(rt_addr, rt_ren, rt_data, imm, h1);
      haz = valid && (h0 || h1);
      rdy = flush || (!haz && (!e_valid || ready_in));
      #1;
      total++;
      if (ready_out !== rdy) begin
        bad++; $display("FAIL rand_ready cyc=%0d got=%b need=%b", cyc, ready_out, rdy);
      end
      if (haz && !flush && e_sc != 32'hFFFF_FFFF) e_sc = e_sc + 1;
      if (flush) e_valid = 0;
      else if (valid && rdy) begin
        e_valid = 1; e_op0 = r0; e_op1 = r1; e_aop = alu_op; e_asel = alu_sel;
        e_wen = ref_wen(wen, wen_cond, r1); e_wa = waddr;
      end else if (ready_in) e_valid = 0;
      tick();
`ifdef ID_STALL_CNT_EN
      e_sc_cfg = e_sc;
`else
      e_sc_cfg = 32'd0;
`endif
      total++;
      if ({valid_out, op0, op1, alu_op_out, alu_sel_out, wen_out, waddr_out, stall_cnt} !==
          {e_valid, e_op0, e_op1, e_aop, e_asel, e_wen, e_wa, e_sc_cfg}) begin
        bad++;
        $display("FAIL rand_regs cyc=%0d got v=%b op0=%h op1=%h aop=%h asel=%h w=%b wa=%h sc=%0d need v=%b op0=%h op1=%h aop=%h asel=%h w=%b wa=%h sc=%0d",
                 cyc, valid_out, op0, op1, alu_op_out, alu_sel_out, wen_out, waddr_out, stall_cnt,
                 e_valid, e_op0, e_op1, e_aop, e_asel, e_wen, e_wa, e_sc_cfg);
      end
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 0;
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_reset_mid_stall();
    test_zero_reg();
    test_cond_write();
    test_hold_flush();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
